// File: rtl/rr_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_n
// Purpose  : NUM_REQ-way round-robin arbiter with time-slice preemption,
//            registered one-hot grant plus encoded index, early release when
//            the holder drops its request, and a slice-expiry pulse.
// Options  : RR_ARB_LOCK_EN - adds the lock port; a locked holder is not
//            preempted by quantum expiry.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter_n #(
  parameter int NUM_REQ = 4,
  parameter int QUANTUM = 16,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_REQ-1:0] req,
`ifdef RR_ARB_LOCK_EN
  input  logic               lock,
`endif
  output logic [NUM_REQ-1:0] grnt,
  output logic [ID_W-1:0]    grnt_id,
  output logic               grnt_vld,
  output logic               slice_exp
);

  localparam int              TW      = $clog2(QUANTUM);
  localparam logic [TW-1:0]   T_LAST  = TW'(QUANTUM - 1);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  if (ID_W != $clog2(NUM_REQ)) begin : g_bad_id_w
    $error("rr_arbiter_n: ID_W must equal $clog2(NUM_REQ)");
  end

  logic [0:0]         state, state_nxt;
  logic [TW-1:0]      timer, timer_nxt;
  logic [ID_W-1:0]    ptr, ptr_nxt;
  logic [NUM_REQ-1:0] grnt_nxt;
  logic [ID_W-1:0]    id_nxt;

  logic [ID_W-1:0]    holder_next;
  logic [ID_W-1:0]    scan_start;
  logic [ID_W-1:0]    winner;
  logic [NUM_REQ-1:0] win_onehot;
  logic               found;
  logic               hold_req;
  logic               at_last;
  logic               locked;
  logic               end_cond;

  // The holder's successor: start of the next scan, so the holder ranks last.
  assign holder_next = (grnt_id == LAST_ID) ? '0 : grnt_id + ID_W'(1);
  assign hold_req    = req[grnt_id];
  assign at_last     = (timer == T_LAST);

`ifdef RR_ARB_LOCK_EN
  assign locked = (state == S_GRANT) && lock && hold_req;
`else
  assign locked = 1'b0;
`endif

  // A grant ends when the holder lets go or its (unlocked) quantum runs out.
  assign end_cond = !hold_req || (at_last && !locked);

  // Find the first requester scanning upward from the scan start, wrapping.
  always_comb begin
    int              idx;
    logic [ID_W-1:0] cand;
    idx        = 0;
    cand       = '0;
    found      = 1'b0;
    winner     = '0;
    win_onehot = '0;
    scan_start = (state == S_IDLE) ? ptr : holder_next;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(scan_start) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      cand = ID_W'(idx);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
    if (found) win_onehot[winner] = 1'b1;
  end

  // State and grant registers; reset may arrive at any time, even mid-grant.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      grnt     <= '0;
      grnt_id  <= '0;
      grnt_vld <= 1'b0;
      timer    <= '0;
      ptr      <= '0;
    end else begin
      state    <= state_nxt;
      grnt     <= grnt_nxt;
      grnt_id  <= id_nxt;
      grnt_vld <= |grnt_nxt;
      timer    <= timer_nxt;
      ptr      <= ptr_nxt;
    end
  end

  // Next-state logic: arbitrate from IDLE, or hold / hand over from GRANT.
  always_comb begin
    state_nxt = state;
    grnt_nxt  = grnt;
    id_nxt    = grnt_id;
    timer_nxt = timer;
    ptr_nxt   = ptr;
    case (state)
      S_IDLE: begin
        if (found) begin
          state_nxt = S_GRANT;
          grnt_nxt  = win_onehot;
          id_nxt    = winner;
          timer_nxt = '0;
        end
      end
      S_GRANT: begin
        if (end_cond) begin
          ptr_nxt   = holder_next;
          timer_nxt = '0;
          if (found) begin
            // Back-to-back handover; may re-grant the same master as a new slice.
            grnt_nxt = win_onehot;
            id_nxt   = winner;
          end else begin
            state_nxt = S_IDLE;
            grnt_nxt  = '0;
            id_nxt    = '0;
          end
        end else if (!at_last) begin
          // Saturates at the last slot while locked.
          timer_nxt = timer + TW'(1);
        end
      end
      default: begin
        state_nxt = S_IDLE;
        grnt_nxt  = '0;
        id_nxt    = '0;
        timer_nxt = '0;
      end
    endcase
  end

  // Expiry pulse only for a live, unlocked holder in its final quantum cycle.
  always_comb begin
    slice_exp = (state == S_GRANT) && at_last && hold_req && !locked;
  end

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter_n
// Purpose  : Self-checking bench for rr_arbiter_n (NUM_REQ=4, QUANTUM=4).
//            A transaction-level model tracks holder / held-cycles / pointer
//            and is compared every cycle; directed scenarios pin literals.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_n;

  localparam int N  = 4;
  localparam int Q  = 4;
  localparam int IW = 2;

  logic          clk;
  logic          resetn;
  logic [N-1:0]  req;
  logic          lock;
  logic [N-1:0]  grnt;
  logic [IW-1:0] grnt_id;
  logic          grnt_vld;
  logic          slice_exp;

  int checks = 0;
  int errors = 0;

  rr_arbiter_n #(.NUM_REQ(N), .QUANTUM(Q), .ID_W(IW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req       (req),
`ifdef RR_ARB_LOCK_EN
    .lock      (lock),
`endif
    .grnt      (grnt),
    .grnt_id   (grnt_id),
    .grnt_vld  (grnt_vld),
    .slice_exp (slice_exp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: holder (-1 when idle), cycles already held, priority pointer.
  typedef struct packed {
    int hold;
    int cnt;
    int ptr;
  } mstate_t;

  mstate_t m = '{hold: -1, cnt: 0, ptr: 0};

  function automatic logic lock_eff();
`ifdef RR_ARB_LOCK_EN
    return lock;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int scan(input int start, input logic [N-1:0] r);
    for (int i = 0; i < N; i++) begin
      if (r[(start + i) % N]) return (start + i) % N;
    end
    return -1;
  endfunction

  function automatic mstate_t step(input mstate_t s, input logic [N-1:0] r, input logic lk);
    mstate_t n;
    logic    held_lock;
    n = s;
    if (s.hold < 0) begin
      n.hold = scan(s.ptr, r);
      n.cnt  = 0;
    end else begin
      held_lock = lk && r[s.hold];
      if (!r[s.hold] || (s.cnt == Q - 1 && !held_lock)) begin
        n.ptr  = (s.hold + 1) % N;
        n.hold = scan(n.ptr, r);
        n.cnt  = 0;
      end else if (s.cnt < Q - 1) begin
        n.cnt = s.cnt + 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) m <= '{hold: -1, cnt: 0, ptr: 0};
    else         m <= step(m, req, lock_eff());
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [N-1:0] eg;
    logic         es;
    eg = '0;
    es = 1'b0;
    if (m.hold >= 0) begin
      eg[m.hold] = 1'b1;
      es = (m.cnt == Q - 1) && req[m.hold] && !lock_eff();
    end
    check("mdl_grnt",      32'(grnt),      32'(eg));
    check("mdl_grnt_id",   32'(grnt_id),   (m.hold >= 0) ? 32'(m.hold) : 32'd0);
    check("mdl_grnt_vld",  32'(grnt_vld),  32'(m.hold >= 0));
    check("mdl_slice_exp", 32'(slice_exp), 32'(es));
  end

  typedef struct {
    logic [N-1:0] v;
    int           cyc;
  } vec_t;

  vec_t vecs [9] = '{
    '{4'b1001, 3}, '{4'b0110, 5}, '{4'b0000, 2}, '{4'b1111, 6}, '{4'b0101, 9},
    '{4'b0011, 4}, '{4'b0000, 1}, '{4'b1000, 3}, '{4'b0000, 3}
  };

  initial begin
    resetn = 1'b1;
    req    = '0;
    lock   = 1'b0;
    #3 resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // Idle after reset with no requests.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("s1_grnt", 32'(grnt), 32'd0);
      check("s1_vld",  32'(grnt_vld), 32'd0);
      check("s1_id",   32'(grnt_id), 32'd0);
    end

    // All requesting: rotate 0,1,2,3,0 with 4-cycle slices and no gap.
    @(posedge clk); #1 req = 4'b1111;
    for (int k = 0; k < 21; k++) begin
      logic [N-1:0] eg;
      eg = '0;
      eg[(k / 4) % 4] = 1'b1;
      @(posedge clk); @(negedge clk);
      check("s2_grnt",  32'(grnt), 32'(eg));
      check("s2_slice", 32'(slice_exp), 32'(k % 4 == 3));
    end

    // Single requester: continuous grant, expiry every 4th cycle.
    @(posedge clk); #1 req = 4'b0000;
    repeat (2) @(posedge clk);
    #1 req = 4'b0100;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); @(negedge clk);
      check("s3_grnt",  32'(grnt), 32'h4);
      check("s3_id",    32'(grnt_id), 32'd2);
      check("s3_slice", 32'(slice_exp), 32'(k % 4 == 3));
    end

    // Early release: master 1 drops after 2 cycles, master 3 takes over.
    @(posedge clk); #1 req = 4'b0000;
    repeat (2) @(posedge clk);
    #1 req = 4'b0010;
    @(posedge clk); #1 req = 4'b1010;
    @(negedge clk);
    check("s4_hold1", 32'(grnt), 32'h2);
    @(posedge clk); #1 req = 4'b1000;
    @(negedge clk);
    check("s4_hold2", 32'(grnt), 32'h2);
    check("s4_noexp", 32'(slice_exp), 32'd0);
    @(posedge clk); @(negedge clk);
    check("s4_handover", 32'(grnt), 32'h8);
    check("s4_id",       32'(grnt_id), 32'd3);

    // Asynchronous reset mid-grant, then the pointer restarts at 0.
    @(posedge clk); #1 req = 4'b1010;
    @(posedge clk); #3 resetn = 1'b0;
    #1;
    check("s5_rst_grnt", 32'(grnt), 32'd0);
    check("s5_rst_vld",  32'(grnt_vld), 32'd0);
    check("s5_rst_id",   32'(grnt_id), 32'd0);
    @(posedge clk); #1 resetn = 1'b1;
    @(posedge clk); @(negedge clk);
    check("s5_first_grnt", 32'(grnt), 32'h2);
    check("s5_first_id",   32'(grnt_id), 32'd1);

`ifdef RR_ARB_LOCK_EN
    // Locked holder keeps the grant past its quantum; release on lock drop.
    @(posedge clk); #3 resetn = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
    req  = 4'b0011;
    lock = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); @(negedge clk);
      check("s6_lock_grnt",  32'(grnt), 32'h1);
      check("s6_lock_slice", 32'(slice_exp), 32'd0);
    end
    @(posedge clk); #1 lock = 1'b0;
    @(posedge clk); @(negedge clk);
    check("s6_unlock_grnt", 32'(grnt), 32'h2);
`endif

    // Mixed directed vectors, checked by the model every cycle.
    lock = 1'b0;
    foreach (vecs[i]) begin
      @(posedge clk); #1 req = vecs[i].v;
      repeat (vecs[i].cyc) @(posedge clk);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("end_idle", 32'(grnt_vld), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
